// File: rtl/cgol_cell.sv
// One cell of a Game of Life grid: a single state flop that can be loaded
// explicitly or advanced one generation using configurable birth/survive masks.
module cgol_cell #(
  parameter logic [8:0] birth_mask_p   = 9'b0_0000_1000,
  parameter logic [8:0] survive_mask_p = 9'b0_0000_1100
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] data_i,
  input  logic       en_i,
  input  logic       update_i,
  input  logic       update_val_i,
  output logic       data_o
);

  localparam int unsigned NbrW   = 8;
  localparam int unsigned CountW = 4;
  localparam int unsigned MaskW  = 16;

  logic              alive_r;
  logic [CountW-1:0] count_c;
  logic              next_c;
  logic [MaskW-1:0]  birth_ext;
  logic [MaskW-1:0]  survive_ext;

  // Masks are zero-extended so every 4-bit count indexes a defined bit.
  assign birth_ext   = MaskW'(birth_mask_p);
  assign survive_ext = MaskW'(survive_mask_p);

  // Neighbour popcount, 0..8.
  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < NbrW; i++) begin
      count_c = count_c + CountW'(data_i[i]);
    end
  end

  always_comb begin
    next_c = 1'b0;
    if (alive_r) next_c = survive_ext[count_c];
    else         next_c = birth_ext[count_c];
  end

  // Reset beats load, load beats generation advance.
  always_ff @(posedge clk_i) begin
    if (reset_i)       alive_r <= 1'b0;
    else if (update_i) alive_r <= update_val_i;
    else if (en_i)     alive_r <= next_c;
  end

  assign data_o = alive_r;

endmodule

// File: tb/tb_cgol_cell.sv
// Self-checking bench for cgol_cell: directed vector table, exhaustive sweep
// of both states against all neighbour patterns, then randomized commands.
module tb_cgol_cell;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       en;
  logic       update;
  logic       update_val;
  logic       data_out;

  int n_cmp = 0;
  int n_err = 0;
  logic model;

  cgol_cell dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .data_i       (data),
    .en_i         (en),
    .update_i     (update),
    .update_val_i (update_val),
    .data_o       (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       upd;
    logic       val;
    logic       en;
    logic [7:0] d;
    logic       exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  // Standard Life: survive on 2 or 3, born on exactly 3.
  function automatic logic life_rule(input logic cur, input logic [7:0] d);
    int n;
    n = $countones(d);
    if (cur) return (n == 2 || n == 3);
    return (n == 3);
  endfunction

  function automatic logic model_step(input logic cur, input logic rst, input logic upd,
                                      input logic val, input logic e, input logic [7:0] d);
    if (rst) return 1'b0;
    if (upd) return val;
    if (e)   return life_rule(cur, d);
    return cur;
  endfunction

  task automatic add(input logic rst, input logic upd, input logic val, input logic e,
                     input logic [7:0] d, input logic exp, input string name);
    vec_t v;
    v.rst = rst; v.upd = upd; v.val = val; v.en = e; v.d = d; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic rst, input logic upd, input logic val, input logic e,
                       input logic [7:0] d, input logic exp, input string name);
    @(negedge clk);
    reset = rst; update = upd; update_val = val; en = e; data = d;
    @(posedge clk);
    #1;
    n_cmp++;
    if (data_out !== exp) begin
      n_err++;
      $display("FAIL %s: data_o=%b expected=%b (rst=%b upd=%b val=%b en=%b data=%h)",
               name, data_out, exp, rst, upd, val, e, d);
    end
  endtask

  initial begin
    logic exp;
    logic r, u, v, e;
    logic [7:0] d;

    reset = 1'b0; data = '0; en = 1'b0; update = 1'b0; update_val = 1'b0;

    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 8'h00, 0, "reset_hold");
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 8'h00, 0, "idle_after_reset");
    add(0, 1, 1, 0, 8'h00, 1, "load_1");
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 8'h00, 1, "hold_1");
    add(0, 1, 0, 0, 8'h00, 0, "load_0");
    add(0, 1, 1, 0, 8'h00, 1, "load_1_b");
    add(0, 0, 0, 1, 8'b0000_0011, 1, "survive_2");
    add(0, 0, 0, 1, 8'b0000_0111, 1, "survive_3");
    add(0, 0, 0, 1, 8'b0000_0001, 0, "die_1");
    add(0, 1, 1, 0, 8'h00, 1, "load_1_c");
    add(0, 0, 0, 1, 8'b0000_1111, 0, "die_4");
    add(0, 1, 1, 0, 8'h00, 1, "load_1_d");
    add(0, 0, 0, 1, 8'hFF, 0, "die_8");
    add(0, 0, 0, 1, 8'b1010_1000, 1, "birth_3");
    add(0, 1, 0, 0, 8'h00, 0, "load_0_b");
    add(0, 0, 0, 1, 8'b0000_0011, 0, "no_birth_2");
    add(0, 0, 0, 1, 8'b0001_1111, 0, "no_birth_5");
    add(0, 0, 0, 1, 8'h00, 0, "no_birth_0");
    add(0, 1, 0, 1, 8'b0000_0111, 0, "load_beats_birth");
    add(0, 1, 1, 0, 8'h00, 1, "load_1_e");
    add(1, 1, 1, 0, 8'h00, 0, "reset_beats_load");
    add(0, 0, 0, 0, 8'h00, 0, "hold_after_reset");
    // Back-to-back generations: born, survive twice, die.
    add(0, 0, 0, 1, 8'b0100_0101, 1, "b2b_birth");
    add(0, 0, 0, 1, 8'b1000_0001, 1, "b2b_survive_2");
    add(0, 0, 0, 1, 8'b0011_0100, 1, "b2b_survive_3");
    add(0, 0, 0, 1, 8'b0111_1100, 0, "b2b_die_5");
    add(0, 1, 1, 0, 8'h00, 1, "load_1_f");
    add(1, 0, 0, 1, 8'b0000_0011, 0, "reset_beats_en");
    add(0, 0, 0, 1, 8'b0000_0011, 0, "dead_after_reset");

    foreach (vecs[i])
      apply(vecs[i].rst, vecs[i].upd, vecs[i].val, vecs[i].en, vecs[i].d, vecs[i].exp, vecs[i].name);

    // Exhaustive: both starting states against every neighbour pattern.
    for (int s = 0; s < 2; s++) begin
      for (int p = 0; p < 256; p++) begin
        d = 8'(p);
        apply(0, 1, 1'(s), 0, 8'h00, 1'(s), "sweep_load");
        apply(0, 0, 0, 1, d, life_rule(1'(s), d), "sweep_gen");
      end
    end

    // Random commands against the behavioural model.
    apply(1, 0, 0, 0, 8'h00, 0, "rand_init_reset");
    model = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 29) == 0);
      u = ($urandom_range(0, 5) == 0);
      v = 1'($urandom);
      e = 1'($urandom);
      d = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'((1 << $urandom_range(0, 7)) | (1 << $urandom_range(0, 7)) | (1 << $urandom_range(0, 7)));
      exp = model_step(model, r, u, v, e, d);
      apply(r, u, v, e, d, exp, "random");
      model = exp;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
